// File: rtl/regwb_if.sv
// Writeback arbiter bus: two requesters, issue-stage reservation, busy query
// and the registered register-file write port.
interface regwb_if;
  logic [1:0]  req_valid;
  logic [4:0]  req_rd0;
  logic [4:0]  req_rd1;
  logic [31:0] req_data0;
  logic [31:0] req_data1;
  logic [1:0]  req_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        rs_busy;
  logic        rt_busy;
  logic        regwrite;
  logic [4:0]  rd;
  logic [31:0] writedata;

  modport slave (
    input  req_valid, req_rd0, req_rd1, req_data0, req_data1,
           rsv_valid, rsv_rd, rs, rt,
    output req_ready, rs_busy, rt_busy, regwrite, rd, writedata
  );

  modport master (
    output req_valid, req_rd0, req_rd1, req_data0, req_data1,
           rsv_valid, rsv_rd, rs, rt,
    input  req_ready, rs_busy, rt_busy, regwrite, rd, writedata
  );
endinterface

// File: rtl/regwb_arbiter.sv
// Round-robin arbiter for ALU/MEM register writeback with a pending-write
// scoreboard for source-operand busy queries.
module regwb_arbiter #(
  parameter int unsigned NREQ = 2
) (
  input logic    clk,
  input logic    rst_n,
  regwb_if.slave bus
);

  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;

  logic            prio_q, prio_d;
  logic [NR-1:0]   busy_q, busy_d;
  logic            regwrite_q, regwrite_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [NREQ-1:0] grant_c;
  logic            contend_c;
  logic            xfer_c;
  logic            sel_c;
  logic [RW-1:0]   xfer_rd_c;
  logic [DW-1:0]   xfer_data_c;

  // Grant: sole requester wins outright; contention resolved by prio.
  always_comb begin
    contend_c = bus.req_valid[0] & bus.req_valid[1];
    grant_c   = NREQ'(bus.req_valid);
    if (contend_c) begin
      grant_c = prio_q ? NREQ'(2'b10) : NREQ'(2'b01);
    end
    if (!rst_n) begin
      grant_c = '0;
    end
    xfer_c      = |grant_c;
    sel_c       = grant_c[1];
    xfer_rd_c   = sel_c ? bus.req_rd1   : bus.req_rd0;
    xfer_data_c = sel_c ? bus.req_data1 : bus.req_data0;
  end

  // Next state: write port, pointer and scoreboard (reservation set wins).
  always_comb begin
    prio_d     = prio_q;
    busy_d     = busy_q;
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    if (xfer_c) begin
      busy_d[xfer_rd_c] = 1'b0;
      if (xfer_rd_c != RW'(0)) begin
        regwrite_d = 1'b1;
        rd_d       = xfer_rd_c;
        wdata_d    = xfer_data_c;
      end
      if (contend_c) begin
        prio_d = ~sel_c;
      end
    end
    if (bus.rsv_valid && (bus.rsv_rd != RW'(0))) begin
      busy_d[bus.rsv_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      busy_q     <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
    end else begin
      prio_q     <= prio_d;
      busy_q     <= busy_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.req_ready = 2'(grant_c);
  assign bus.rs_busy   = busy_q[bus.rs];
  assign bus.rt_busy   = busy_q[bus.rt];
  assign bus.regwrite  = regwrite_q;
  assign bus.rd        = rd_q;
  assign bus.writedata = wdata_q;

endmodule
